// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 64-bit ALU between NUM_REQ requesters.
// Requesters are granted round-robin. The ALU result is registered into a single
// tagged response slot with valid/ready backpressure, so accept-to-response latency
// is one cycle and back-to-back issue reaches one command per cycle.
// Optional build macro: ALU_ARB_PRIO0_EN gives requester 0 fixed priority over
// the round-robin group.
module alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [5*NUM_REQ-1:0]    req_op,
  input  logic [NUM_REQ-1:0]      req_sub_sra,
  input  logic [3*NUM_REQ-1:0]    req_src1,
  input  logic [3*NUM_REQ-1:0]    req_src2,
  input  logic [64*NUM_REQ-1:0]   req_pc,
  input  logic [64*NUM_REQ-1:0]   req_rs1,
  input  logic [64*NUM_REQ-1:0]   req_rs2,
  input  logic [64*NUM_REQ-1:0]   req_imm,
  output logic [4:0]              alu_op_out,
  output logic                    alu_sub_sra_out,
  output logic [2:0]              alu_src1_out,
  output logic [2:0]              alu_src2_out,
  output logic [63:0]             alu_pc_out,
  output logic [63:0]             alu_rs1_out,
  output logic [63:0]             alu_rs2_out,
  output logic [63:0]             alu_imm_out,
  input  logic [63:0]             alu_result_in,
  input  logic                    alu_non_zero_in,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [63:0]             rsp_result,
  output logic                    rsp_non_zero
);

  localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] rr_next;
  logic            can_issue;
  logic            grant;

  // The response slot can take a new result when empty or draining; nothing
  // is granted while reset is held so requesters never see a stray accept.
  always_comb begin
    can_issue = rst_n && (!rsp_valid || rsp_ready);
  end

  // Pick the first valid requester at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic [ID_W:0] scan_idx;
    logic          cand;
    grant    = 1'b0;
    winner   = rr_ptr;
    scan_idx = '0;
    cand     = 1'b0;
    if (can_issue) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
        if (scan_idx >= NUM_REQ_W) begin
          scan_idx = scan_idx - NUM_REQ_W;
        end
        cand = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (scan_idx == (ID_W+1)'(i)) begin
            cand = req_valid[i];
          end
        end
        if (!grant && cand) begin
          grant  = 1'b1;
          winner = scan_idx[ID_W-1:0];
        end
      end
`ifdef ALU_ARB_PRIO0_EN
      // Requester 0 overrides whatever the rotation chose.
      if (req_valid[0]) begin
        grant  = 1'b1;
        winner = '0;
      end
`endif
    end
  end

  // One-hot accept to the winner only.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant && (winner == ID_W'(i));
    end
  end

  // Steer the selected requester's command to the ALU; with no grant winner
  // equals rr_ptr, which keeps the outputs deterministic.
  always_comb begin
    alu_op_out      = req_op[4:0];
    alu_sub_sra_out = req_sub_sra[0];
    alu_src1_out    = req_src1[2:0];
    alu_src2_out    = req_src2[2:0];
    alu_pc_out      = req_pc[63:0];
    alu_rs1_out     = req_rs1[63:0];
    alu_rs2_out     = req_rs2[63:0];
    alu_imm_out     = req_imm[63:0];
    for (int i = 1; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        alu_op_out      = req_op[5*i +: 5];
        alu_sub_sra_out = req_sub_sra[i];
        alu_src1_out    = req_src1[3*i +: 3];
        alu_src2_out    = req_src2[3*i +: 3];
        alu_pc_out      = req_pc[64*i +: 64];
        alu_rs1_out     = req_rs1[64*i +: 64];
        alu_rs2_out     = req_rs2[64*i +: 64];
        alu_imm_out     = req_imm[64*i +: 64];
      end
    end
  end

  // Rotation target after a grant: the requester just above the winner.
  always_comb begin
    rr_next = (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + ID_W'(1);
  end

  // Response slot and rotation pointer; a grant overwrites a draining response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_result   <= '0;
      rsp_non_zero <= 1'b0;
      rr_ptr       <= '0;
    end else if (grant) begin
      rsp_valid    <= 1'b1;
      rsp_id       <= winner;
      rsp_result   <= alu_result_in;
      rsp_non_zero <= alu_non_zero_in;
`ifdef ALU_ARB_PRIO0_EN
      if (winner != '0) begin
        rr_ptr <= rr_next;
      end
`else
      rr_ptr <= rr_next;
`endif
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
